// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, fetch FSM states.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DONE    = 2'd1,
        S_WAIT_PC = 2'd2,
        S_STOP    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/y86_instr_len.sv
// Combinational instruction-length decoder: icode -> length and field presence.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] length,
    output logic       need_regids,
    output logic       need_valc,
    output logic       valid
);

    always_comb begin
        length      = 4'd1;
        need_regids = 1'b0;
        need_valc   = 1'b0;
        valid       = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                length = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                length      = 4'd2;
                need_regids = 1'b1;
            end
            I_JXX, I_CALL: begin
                length    = 4'd9;
                need_valc = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                length      = 4'd10;
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            default: begin
                // Unknown icodes consume a single byte and are flagged invalid.
                length = 4'd1;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y86_fetch_seq.sv
// Sequential Y86-64 fetch unit: reads an instruction byte-serially and presents
// the decoded fields through a valid/ready handshake.
module y86_fetch_seq
    import y86_pkg::*;
#(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_load,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    input  logic              mem_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [2:0]        stat,
    output logic              busy
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [7:0]        byte_reg [10];

    logic              out_valid_reg, out_valid_next;
    logic [3:0]        icode_reg, icode_next;
    logic [3:0]        ifun_reg, ifun_next;
    logic [3:0]        ra_reg, ra_next;
    logic [3:0]        rb_reg, rb_next;
    logic [63:0]       valc_reg, valc_next;
    logic [ADDR_W-1:0] valp_reg, valp_next;
    logic [2:0]        stat_reg, stat_next;

    // Byte view with the byte arriving this cycle already merged into its slot,
    // so the final byte can be decoded in the same cycle it is acknowledged.
    logic [7:0]        byte_m [10];
    logic [63:0]       valc_a, valc_b;
    logic [3:0]        len;
    logic              need_regids, need_valc, icode_ok;
    logic              last_byte;
    logic              fetching;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_merge
            assign byte_m[gi] = (cnt_reg == 4'(gi)) ? mem_rdata : byte_reg[gi];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_valc
            assign valc_a[gi*8 +: 8] = byte_m[gi+1];
            assign valc_b[gi*8 +: 8] = byte_m[gi+2];
        end
    endgenerate

    y86_instr_len u_len (
        .icode       (byte_m[0][7:4]),
        .length      (len),
        .need_regids (need_regids),
        .need_valc   (need_valc),
        .valid       (icode_ok)
    );

    assign last_byte = ((cnt_reg + 4'd1) == len);
    assign fetching  = (state_reg == S_FETCH);

    // Request is killed combinationally by rst so it drops the moment reset asserts.
    assign mem_req   = fetching & ~rst;
    assign busy      = fetching & ~rst;
    assign mem_addr  = pc_reg + ADDR_W'(cnt_reg);

    assign out_valid = out_valid_reg;
    assign icode     = icode_reg;
    assign ifun      = ifun_reg;
    assign rA        = ra_reg;
    assign rB        = rb_reg;
    assign valC      = valc_reg;
    assign valP      = valp_reg;
    assign stat      = stat_reg;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        icode_next     = icode_reg;
        ifun_next      = ifun_reg;
        ra_next        = ra_reg;
        rb_next        = rb_reg;
        valc_next      = valc_reg;
        valp_next      = valp_reg;
        stat_next      = stat_reg;
        case (state_reg)
            S_FETCH: begin
                if (pc_load) begin
                    pc_next  = pc_in;
                    cnt_next = 4'd0;
                end else if (mem_ack) begin
                    if (mem_err) begin
                        state_next     = S_DONE;
                        cnt_next       = 4'd0;
                        out_valid_next = 1'b1;
                        icode_next     = (cnt_reg != 4'd0) ? byte_reg[0][7:4] : 4'h0;
                        ifun_next      = (cnt_reg != 4'd0) ? byte_reg[0][3:0] : 4'h0;
                        ra_next        = REG_NONE;
                        rb_next        = REG_NONE;
                        valc_next      = '0;
                        valp_next      = pc_reg;
                        stat_next      = STAT_ADR;
                    end else if (last_byte) begin
                        state_next     = S_DONE;
                        cnt_next       = 4'd0;
                        out_valid_next = 1'b1;
                        icode_next     = byte_m[0][7:4];
                        ifun_next      = byte_m[0][3:0];
                        ra_next        = need_regids ? byte_m[1][7:4] : REG_NONE;
                        rb_next        = need_regids ? byte_m[1][3:0] : REG_NONE;
                        valc_next      = !need_valc ? 64'd0 : (need_regids ? valc_b : valc_a);
                        valp_next      = pc_reg + ADDR_W'(len);
                        if (!icode_ok)
                            stat_next = STAT_INS;
                        else if (byte_m[0][7:4] == I_HALT)
                            stat_next = STAT_HLT;
                        else
                            stat_next = STAT_AOK;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (pc_load) begin
                    // Covers both a plain abort and a load coincident with a transfer.
                    state_next     = S_FETCH;
                    pc_next        = pc_in;
                    cnt_next       = 4'd0;
                    out_valid_next = 1'b0;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = (stat_reg == STAT_AOK) ? S_WAIT_PC : S_STOP;
                end
            end
            S_WAIT_PC: begin
                if (pc_load) begin
                    state_next = S_FETCH;
                    pc_next    = pc_in;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = S_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            pc_reg        <= RESET_PC;
            cnt_reg       <= 4'd0;
            out_valid_reg <= 1'b0;
            icode_reg     <= 4'h0;
            ifun_reg      <= 4'h0;
            ra_reg        <= REG_NONE;
            rb_reg        <= REG_NONE;
            valc_reg      <= '0;
            valp_reg      <= '0;
            stat_reg      <= STAT_AOK;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            icode_reg     <= icode_next;
            ifun_reg      <= ifun_next;
            ra_reg        <= ra_next;
            rb_reg        <= rb_next;
            valc_reg      <= valc_next;
            valp_reg      <= valp_next;
            stat_reg      <= stat_next;
        end
    end

    // Byte buffer needs no reset: every slot is rewritten before it is consumed.
    always_ff @(posedge clk) begin
        if (fetching && mem_ack && !mem_err && !pc_load && cnt_reg < 4'd10)
            byte_reg[cnt_reg] <= mem_rdata;
    end

endmodule

// File: tb/tb_y86_fetch_seq.sv
// Directed self-checking bench for y86_fetch_seq with a behavioural byte memory.
module tb_y86_fetch_seq;

    logic        clk;
    logic        rst;
    logic [63:0] pc_in;
    logic        pc_load;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          req_cycles = 0;
    int          rc0;
    int          ncyc;

    logic [7:0]  mem [256];
    int          nwait;
    int          wcnt;
    logic        err_en;
    logic [63:0] err_addr;

    y86_fetch_seq #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .pc_load   (pc_load),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .valP      (valP),
        .stat      (stat),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_ack   = mem_req && (wcnt == nwait);
    assign mem_err   = mem_ack && err_en && (mem_addr == err_addr);
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    always @(negedge clk) begin
        if (mem_req) req_cycles <= req_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
        $display("txn: icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d cycles=%0d",
                 icode, ifun, rA, rB, valC, valP, stat, n);
    endtask

    task automatic load_pc(input logic [63:0] pc, input logic with_ready);
        pc_in     = pc;
        pc_load   = 1'b1;
        out_ready = with_ready;
        rc0       = req_cycles;
        @(posedge clk); #1;
        pc_load   = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_in = '0; pc_load = 1'b0; out_ready = 1'b0;
        nwait = 0; err_en = 1'b0; err_addr = '0; wcnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // irmovq $4,%rsp
        mem[8'h00] = 8'h30; mem[8'h01] = 8'hF4; mem[8'h02] = 8'h04;
        // call 0x100
        mem[8'h20] = 8'h80; mem[8'h21] = 8'h00; mem[8'h22] = 8'h01;
        mem[8'h40] = 8'h10;
        mem[8'h50] = 8'h60; mem[8'h51] = 8'h12;
        mem[8'h60] = 8'hC0;
        mem[8'h70] = 8'h00;
        mem[8'hFF] = 8'h20;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_rA", {60'd0, rA}, 64'hF);
        check("rst_rB", {60'd0, rB}, 64'hF);
        check("rst_stat", {61'd0, stat}, 64'd1);
        check("rst_valC", valC, 64'd0);
        check("rst_valP", valP, 64'd0);

        // irmovq from RESET_PC, zero-wait memory
        rst = 1'b0;
        rc0 = req_cycles;
        wait_valid(ncyc);
        check("irmovq_latency", 64'(ncyc), 64'd10);
        check("irmovq_req_cycles", 64'(req_cycles - rc0), 64'd10);
        check("irmovq_icode", {60'd0, icode}, 64'd3);
        check("irmovq_ifun", {60'd0, ifun}, 64'd0);
        check("irmovq_rA", {60'd0, rA}, 64'hF);
        check("irmovq_rB", {60'd0, rB}, 64'h4);
        check("irmovq_valC", valC, 64'd4);
        check("irmovq_valP", valP, 64'd10);
        check("irmovq_stat", {61'd0, stat}, 64'd1);
        check("irmovq_busy", {63'd0, busy}, 64'd0);

        // Hold in DONE with out_ready low
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_valC", valC, 64'd4);
            check("hold_valP", valP, 64'd10);
            check("hold_rB", {60'd0, rB}, 64'h4);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("xfer_valid_drop", {63'd0, out_valid}, 64'd0);
        check("waitpc_mem_req", {63'd0, mem_req}, 64'd0);

        // call 0x100 with two wait states per byte
        nwait = 2;
        load_pc(64'h20, 1'b0);
        wait_valid(ncyc);
        check("call_req_cycles", 64'(req_cycles - rc0), 64'd27);
        check("call_icode", {60'd0, icode}, 64'd8);
        check("call_valC", valC, 64'h100);
        check("call_valP", valP, 64'h29);
        check("call_rA", {60'd0, rA}, 64'hF);
        check("call_stat", {61'd0, stat}, 64'd1);
        nwait = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // rrmovq straddling the top of the address space
        load_pc(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_valid(ncyc);
        check("wrap_req_cycles", 64'(req_cycles - rc0), 64'd2);
        check("wrap_icode", {60'd0, icode}, 64'd2);
        check("wrap_rA", {60'd0, rA}, 64'h3);
        check("wrap_rB", {60'd0, rB}, 64'h0);
        check("wrap_valP", valP, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // OPq with address error on its second byte
        err_en = 1'b1; err_addr = 64'h51;
        load_pc(64'h50, 1'b0);
        wait_valid(ncyc);
        check("adr_req_cycles", 64'(req_cycles - rc0), 64'd2);
        check("adr_stat", {61'd0, stat}, 64'd3);
        check("adr_valP", valP, 64'h50);
        check("adr_icode", {60'd0, icode}, 64'd6);
        err_en = 1'b0;

        // Load coincident with transfer of a non-AOK instruction: invalid icode
        load_pc(64'h60, 1'b1);
        check("restart_addr", mem_addr, 64'h60);
        check("restart_valid", {63'd0, out_valid}, 64'd0);
        wait_valid(ncyc);
        check("ins_req_cycles", 64'(req_cycles - rc0), 64'd1);
        check("ins_stat", {61'd0, stat}, 64'd4);
        check("ins_icode", {60'd0, icode}, 64'hC);
        check("ins_valP", valP, 64'h61);

        // halt, then STOP
        load_pc(64'h70, 1'b1);
        wait_valid(ncyc);
        check("hlt_stat", {61'd0, stat}, 64'd2);
        check("hlt_valP", valP, 64'h71);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stop_busy", {63'd0, busy}, 64'd0);
        load_pc(64'h20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("stop_ignores_load_busy", {63'd0, busy}, 64'd0);
        check("stop_mem_req", {63'd0, mem_req}, 64'd0);
        check("stop_out_valid", {63'd0, out_valid}, 64'd0);

        // Leave STOP through reset; redirect on the 3rd fetch cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("redir_pre_addr", mem_addr, 64'd2);
        load_pc(64'h40, 1'b0);
        check("redir_addr", mem_addr, 64'h40);
        check("redir_req", {63'd0, mem_req}, 64'd1);
        check("redir_no_old_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("redir_valid", {63'd0, out_valid}, 64'd1);
        check("redir_icode", {60'd0, icode}, 64'd1);
        check("redir_valP", valP, 64'h41);
        $display("txn: icode=%h valP=%h stat=%0d (redirected nop)", icode, valP, stat);

        // Reset asserted in the middle of a fetch
        load_pc(64'h0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rc0 = req_cycles;
        wait_valid(ncyc);
        check("refetch_req_cycles", 64'(req_cycles - rc0), 64'd10);
        check("refetch_valC", valC, 64'd4);
        check("refetch_valP", valP, 64'd10);
        check("refetch_icode", {60'd0, icode}, 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
